pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 147 ++++++++++++++
 tb/tb_pc_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-PC sequencer: turns boot, redirects, traps, hazards and debug halt into stall/flush controls.
// Controls are combinational in the same cycle; a redirect that meets a stalled imem is parked in WAIT until imem_ready.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_ready,
  input  logic             hazard_stall,
  input  logic             redirect_e,
  input  logic [31:0]      redirect_pc,
  input  logic             trap_req,
  input  logic [31:0]      trap_pc,
  input  logic             halt_req,
  input  logic             resume,
  output logic             stallF,
  output logic             stallD,
  output logic             flushF,
  output logic             flushD,
  output logic             flushE,
  output logic [31:0]      pc_restore,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_HALT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic        evt;
  logic [31:0] evt_pc;

  // Trap outranks a branch redirect resolved in the same cycle.
  assign evt    = trap_req | redirect_e;
  assign evt_pc = trap_req ? trap_pc : redirect_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_BOOT;
      pend_pc_q   <= RESET_PC;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_pc_q   <= pend_pc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (evt) begin
          pend_pc_d = evt_pc;
          if (!imem_ready) state_d = S_WAIT;
        end else if (!hazard_stall && halt_req) begin
          state_d = S_HALT;
        end
      end
      S_WAIT: begin
        if (evt) pend_pc_d = evt_pc;
        if (imem_ready) state_d = S_RUN;
      end
      S_HALT: begin
        if (trap_req || resume) state_d = S_RUN;
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    stallF     = 1'b0;
    stallD     = 1'b0;
    flushF     = 1'b0;
    flushD     = 1'b0;
    flushE     = 1'b0;
    halted     = 1'b0;
    pc_restore = pend_pc_q;
    case (state_q)
      S_BOOT: begin
        flushF     = 1'b1;
        flushD     = 1'b1;
        flushE     = 1'b1;
        pc_restore = RESET_PC;
      end
      S_RUN: begin
        if (evt) begin
          flushD = 1'b1;
          flushE = 1'b1;
          if (imem_ready) begin
            flushF     = 1'b1;
            pc_restore = evt_pc;
          end else begin
            stallF = 1'b1;
          end
        end else if (hazard_stall) begin
          stallF = 1'b1;
          stallD = 1'b1;
          flushE = 1'b1;
        end else if (!imem_ready) begin
          stallF = 1'b1;
          flushD = 1'b1;
        end
      end
      S_WAIT: begin
        if (evt) flushE = 1'b1;
        // A target arriving with the returning word bypasses pend_pc.
        if (imem_ready) begin
          flushF     = 1'b1;
          pc_restore = evt ? evt_pc : pend_pc_q;
        end else begin
          stallF = 1'b1;
          flushD = 1'b1;
        end
      end
      S_HALT: begin
        halted = 1'b1;
        stallF = 1'b1;
        flushD = 1'b1;
        if (trap_req) begin
          flushF     = 1'b1;
          pc_restore = trap_pc;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stallF && !flushF && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a cycle-level reference model checked every cycle plus literal spot checks.
module tb_pc_sequencer;

  localparam int TB_CNT_W = 4;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                imem_ready, hazard_stall, redirect_e, trap_req, halt_req, resume;
  logic [31:0]         redirect_pc, trap_pc;
  logic                stallF, stallD, flushF, flushD, flushE, halted;
  logic [31:0]         pc_restore;
  logic [TB_CNT_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_errs   = 0;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .imem_ready(imem_ready), .hazard_stall(hazard_stall),
    .redirect_e(redirect_e), .redirect_pc(redirect_pc), .trap_req(trap_req), .trap_pc(trap_pc),
    .halt_req(halt_req), .resume(resume), .stallF(stallF), .stallD(stallD), .flushF(flushF),
    .flushD(flushD), .flushE(flushE), .pc_restore(pc_restore), .halted(halted), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the sequencer's mode as plain flags, pending target, stall count.
  bit        m_valid = 0, m_boot, m_wait, m_halt;
  bit        n_boot, n_wait, n_halt;
  bit [31:0] m_pend, n_pend;
  int        m_cnt, n_cnt;

  always @(negedge clk) begin : model_cmp
    bit        e_sF, e_sD, e_fF, e_fD, e_fE, e_h, ev;
    bit [31:0] e_pc, tgt;
    {e_sF, e_sD, e_fF, e_fD, e_fE, e_h} = '0;
    e_pc = m_pend;
    ev   = trap_req | redirect_e;
    tgt  = trap_req ? trap_pc : redirect_pc;
    n_boot = 0; n_wait = m_wait; n_halt = m_halt; n_pend = m_pend;
    if (m_boot) begin
      {e_fF, e_fD, e_fE} = 3'b111; e_pc = 32'h0;
    end else if (m_halt) begin
      e_h = 1; e_sF = 1; e_fD = 1;
      if (trap_req) begin e_fF = 1; e_pc = trap_pc; n_halt = 0; end
      else if (resume) n_halt = 0;
    end else if (m_wait) begin
      if (ev) begin e_fE = 1; n_pend = tgt; end
      if (imem_ready) begin e_fF = 1; e_pc = ev ? tgt : m_pend; n_wait = 0; end
      else begin e_sF = 1; e_fD = 1; end
    end else if (ev) begin
      e_fD = 1; e_fE = 1; n_pend = tgt;
      if (imem_ready) begin e_fF = 1; e_pc = tgt; end
      else begin e_sF = 1; n_wait = 1; end
    end else if (hazard_stall) begin
      e_sF = 1; e_sD = 1; e_fE = 1;
    end else begin
      if (!imem_ready) begin e_sF = 1; e_fD = 1; end
      if (halt_req) n_halt = 1;
    end
    n_cnt = (e_sF && !e_fF && m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
    if (m_valid && rst_n === 1'b1) begin
      chk("m_stallF", stallF, e_sF);
      chk("m_stallD", stallD, e_sD);
      chk("m_flushF", flushF, e_fF);
      chk("m_flushD", flushD, e_fD);
      chk("m_flushE", flushE, e_fE);
      chk("m_halted", halted, e_h);
      chk("m_stall_cnt", stall_cnt, m_cnt);
      if (e_fF) chk("m_pc_restore", pc_restore, e_pc);
    end
  end

  always @(posedge clk) begin
    if (rst_n !== 1'b1) begin
      m_valid = 1; m_boot = 1; m_wait = 0; m_halt = 0; m_pend = 32'h0; m_cnt = 0;
    end else if (m_valid) begin
      m_boot = n_boot; m_wait = n_wait; m_halt = n_halt; m_pend = n_pend; m_cnt = n_cnt;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    redirect_e = 0; trap_req = 0; halt_req = 0; resume = 0; hazard_stall = 0;
  endtask

  initial begin
    rst_n = 0; imem_ready = 1; redirect_pc = 0; trap_pc = 0;
    idle();
    nxt(); nxt();
    rst_n = 1;
    @(negedge clk);
    chk("boot_flushF", flushF, 1); chk("boot_flushD", flushD, 1);
    chk("boot_flushE", flushE, 1); chk("boot_pc", pc_restore, 32'h0);
    nxt(); @(negedge clk);
    chk("run_ctrl", {stallF, stallD, flushF, flushD, flushE}, 0);
    chk("run_cnt", stall_cnt, 0);
    // redirect while imem stalled, parked for 3 more cycles
    nxt(); redirect_e = 1; redirect_pc = 32'h200; imem_ready = 0; @(negedge clk);
    chk("wait_in_stallF", stallF, 1); chk("wait_in_flushE", flushE, 1); chk("wait_in_flushF", flushF, 0);
    for (int i = 0; i < 3; i++) begin
      nxt(); redirect_e = 0; @(negedge clk);
      chk("wait_stallF", stallF, 1);
    end
    nxt(); imem_ready = 1; @(negedge clk);
    chk("wait_out_flushF", flushF, 1); chk("wait_out_pc", pc_restore, 32'h200);
    nxt(); @(negedge clk);
    chk("wait_cnt", stall_cnt, 4);
    nxt(); redirect_e = 1; redirect_pc = 32'h100; @(negedge clk);
    chk("redir_flush", {flushF, flushD, flushE}, 3'b111); chk("redir_pc", pc_restore, 32'h100);
    nxt(); trap_req = 1; trap_pc = 32'h80; @(negedge clk);
    chk("trap_prio_pc", pc_restore, 32'h80);
    for (int i = 0; i < 2; i++) begin
      nxt(); idle(); hazard_stall = 1; @(negedge clk);
      chk("hazard_ctrl", {stallF, stallD, flushF, flushE}, 4'b1101);
    end
    nxt(); idle();
    // new event coincident with imem_ready in WAIT
    nxt(); redirect_e = 1; redirect_pc = 32'h300; imem_ready = 0;
    nxt(); redirect_e = 0; trap_req = 1; trap_pc = 32'h40; @(negedge clk);
    chk("wait_evt_flushE", flushE, 1); chk("wait_evt_flushF", flushF, 0);
    nxt(); trap_req = 0; redirect_e = 1; redirect_pc = 32'h500; imem_ready = 1; @(negedge clk);
    chk("wait_bypass_pc", pc_restore, 32'h500);
    nxt(); idle(); redirect_e = 1; redirect_pc = 32'h300; imem_ready = 0;
    nxt(); redirect_e = 0; trap_req = 1; trap_pc = 32'h44;
    nxt(); trap_req = 0; imem_ready = 1; @(negedge clk);
    chk("wait_overwrite_pc", pc_restore, 32'h44);
    // halt_req dropped when it meets an event or a hazard
    nxt(); halt_req = 1; redirect_e = 1; redirect_pc = 32'h600;
    nxt(); idle(); @(negedge clk);
    chk("halt_evt_ignored", halted, 0);
    nxt(); halt_req = 1; hazard_stall = 1;
    nxt(); idle(); @(negedge clk);
    chk("halt_hz_ignored", halted, 0);
    nxt(); halt_req = 1; imem_ready = 0; @(negedge clk);
    chk("halt_req_cycle", {halted, stallF, flushD}, 3'b011);
    nxt(); halt_req = 0; imem_ready = 1; @(negedge clk);
    chk("halted_set", halted, 1); chk("halted_stallF", stallF, 1);
    nxt(); redirect_e = 1; redirect_pc = 32'h700; @(negedge clk);
    chk("halt_redir_flushF", flushF, 0);
    nxt(); redirect_e = 0; resume = 1; @(negedge clk);
    chk("resume_cycle", halted, 1);
    nxt(); resume = 0; @(negedge clk);
    chk("resumed", halted, 0);
    nxt(); halt_req = 1;
    nxt(); halt_req = 0;
    repeat (20) nxt();
    @(negedge clk);
    chk("cnt_saturated", stall_cnt, CNT_MAX);
    nxt(); trap_req = 1; trap_pc = 32'h80; resume = 1; @(negedge clk);
    chk("halt_trap_flushF", flushF, 1); chk("halt_trap_pc", pc_restore, 32'h80);
    nxt(); idle(); @(negedge clk);
    chk("halt_trap_exit", halted, 0);
    // reset while a redirect is parked
    nxt(); redirect_e = 1; redirect_pc = 32'h900; imem_ready = 0;
    nxt(); idle(); rst_n = 0;
    nxt(); rst_n = 1; imem_ready = 1; @(negedge clk);
    chk("rst_boot_pc", pc_restore, 32'h0); chk("rst_boot_flushF", flushF, 1);
    chk("rst_cnt", stall_cnt, 0);
    nxt(); @(negedge clk);
    chk("rst_no_pending", {stallF, flushF}, 0);
    nxt();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
